scmp_mem_arbiter: RTL and testbench
===================================

# scmp_mem_arbiter

Single-clock arbiter sharing the board's single-port synchronous program/data RAM between the SC/MP CPU bus and a debug/loader port. CPU strobes (`RD_n`/`WR_n`) come from the slow, divided CPU clock domain. They are synchronised into the 50 MHz system clock and serviced with fixed priority. Debug accesses (memory load/peek from a UART monitor) use the idle slots. The block replaces the asynchronous strobe-edge memory model on the board top level.

## Interface
Parameters:
- `ADDR_W`, 7: RAM address width (128 bytes); CPU address is truncated to `ADDR_W` LSBs.
- `DATA_W`, 8: data width.

Ports:
- `clk` in 1: system clock (50 MHz). One clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_addr` in 12: CPU address bus, stable while a strobe is low.
- `cpu_d_o` in 8: CPU write data, stable while `cpu_wr_n` is low.
- `cpu_rd_n` in 1: CPU read strobe, active low, asynchronous to `clk`.
- `cpu_wr_n` in 1: CPU write strobe, active low, asynchronous to `clk`.
- `cpu_d_i` out 8: read data to CPU. Equals `cpu_rdata_q` while `cpu_rd_n` (raw) is low, else 8'hFF.
- `dbg_req` in 1: debug request level, held until `dbg_ack`.
- `dbg_we` in 1: debug write (1) / read (0).
- `dbg_addr` in `ADDR_W`: debug address.
- `dbg_wdata` in 8: debug write data.
- `dbg_ack` out 1: one-cycle completion pulse.
- `dbg_rdata` out 8: debug read data, valid from the `dbg_ack` cycle until the next debug read completes.
- `ram_addr` out `ADDR_W`: RAM address (registered).
- `ram_we` out 1: RAM write enable (registered).
- `ram_wdata` out 8: RAM write data (registered).
- `ram_rdata` in 8: RAM read data, one-cycle synchronous latency after `ram_addr`.
- `bus_err` out 1: sticky error flag, cleared only by `rst`.

## Operation
- Strobe synchronisers: 2-FF sync per strobe, reset to 1. A falling edge of the synced strobe sets `cpu_rd_pend` / `cpu_wr_pend`.
  - Address and data are captured into `cpu_addr_q` / `cpu_wdata_q` in the same cycle as the edge.
- FSM states: IDLE, CRD, CRD_CAP, CWR, DRD, DRD_CAP, DWR.
- Transitions out of IDLE are evaluated each cycle, priority highest first:
  - `cpu_wr_pend` → CWR.
  - `cpu_rd_pend` → CRD.
  - `dbg_req` && !`dbg_ack` → DWR / DRD, according to `dbg_we`. Debug address and data are latched on entry.
- CWR: `ram_we`=1 for one cycle with the captured address/data; clears `cpu_wr_pend`; → IDLE.
- CRD: `ram_addr` driven; clears `cpu_rd_pend`; → CRD_CAP.
- CRD_CAP: `cpu_rdata_q` ← `ram_rdata`; → IDLE.
- DWR: `ram_we`=1; `dbg_ack` pulses the next cycle; → IDLE.
- DRD → DRD_CAP: `dbg_rdata` ← `ram_rdata`; `dbg_ack` pulses the next cycle; → IDLE.
- Fixed priority is sufficient. A CPU access period is thousands of `clk` cycles, so the debug port is never starved.
- Boundary conditions:
  - Both synced strobes fall in the same cycle: treated as a write; `bus_err` set.
  - A new CPU edge arrives while the same-type pend is still set: overrun; `bus_err` set; the newer address/data overwrite the pending ones.
  - A CPU edge arriving during a debug transaction waits; the debug transaction always completes first.
  - The `dbg_req` level seen in the `dbg_ack` cycle is ignored. The requester drops `dbg_req` the cycle after `dbg_ack`; holding it high starts a new transaction one cycle later.
  - `rst` mid-operation: FSM → IDLE, all pends cleared, an in-flight debug transaction is abandoned (no ack).

## Timing
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `dbg_ack`=0, `dbg_rdata`=0, `cpu_rdata_q`=8'hFF, `bus_err`=0.
- CPU read latency, raw `cpu_rd_n` fall to `cpu_d_i` valid: 2 sync + 1 IDLE decode + 1 CRD + 1 CRD_CAP = at most 5 cycles. If a debug transaction is in flight, add up to 3 cycles, giving a worst case of 8 cycles. This is well inside the CPU strobe width.
- CPU write commit: at most 4 cycles after the raw `cpu_wr_n` fall, plus up to 3 cycles of debug blocking.
- Debug latency, from the cycle `dbg_req` is seen in IDLE to `dbg_ack`: 2 cycles for a write, 3 cycles for a read.
- `cpu_d_i` mux uses the raw `cpu_rd_n` (combinational). It returns 8'hFF as soon as the strobe rises.

## Structure
- Shared package `scmp_mem_pkg` holds:
  - the `arb_state_t` enum (7 states above);
  - `IDLE_DATA` = 8'hFF;
  - default `ADDR_W` = 7.
- Sub-module `strobe_sync`: 2-FF synchroniser plus falling-edge detect, reset value 1, output `fall` pulse. Instantiated twice.

## Test plan
- Reset: assert `rst` mid-CRD → next cycle `ram_we`=0, `cpu_d_i`=8'hFF, `bus_err`=0, no `dbg_ack`.
- CPU read: preload RAM[0x05]=0x3C; drive `cpu_addr`=0x085, `cpu_rd_n` low → `cpu_d_i`=0x3C within 5 cycles; after `cpu_rd_n` rises, `cpu_d_i`=0xFF.
- CPU write: `cpu_addr`=0x012, `cpu_d_o`=0xA5, `cpu_wr_n` low → one `ram_we` pulse at addr 0x12 within 4 cycles; a debug read of 0x12 returns 0xA5.
- Contention: `dbg_req` read of 0x20 accepted; `cpu_wr_n` falls 1 cycle later → debug ack arrives first, then the CPU write completes within 8 cycles of its strobe; `bus_err`=0.
- Overrun: two `cpu_rd_n` pulses of 1-cycle width, spaced 2 `clk` apart → `bus_err`=1 and stays 1 until `rst`.
- Simultaneous strobes: `cpu_rd_n` and `cpu_wr_n` fall together → write performed, no read capture, `bus_err`=1.

Source files
------------

// File: rtl/scmp_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scmp_mem_pkg
// Brief    : Shared types and constants for the SC/MP memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package scmp_mem_pkg;

    localparam int unsigned c_DEFAULT_ADDR_W = 7;
    localparam logic [7:0]  c_IDLE_DATA      = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CRD     = 3'd1,
        ST_CRD_CAP = 3'd2,
        ST_CWR     = 3'd3,
        ST_DRD     = 3'd4,
        ST_DRD_CAP = 3'd5,
        ST_DWR     = 3'd6
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/scmp_mem_arbiter_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module   : strobe_sync
// Brief    : Two-stage synchroniser for an active-low strobe with fall detect.
// Revision : 1.0 - initial release
// ============================================================================
module strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic strobe_n,
    output logic fall
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= strobe_n;
            r_sync <= r_meta;
        end
    end

    // Edge taken across the two stages so the request registers on the second clock.
    assign fall = r_sync & ~r_meta;

endmodule
`default_nettype wire

// File: rtl/scmp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : scmp_mem_arbiter
// Brief    : Shares one synchronous RAM between the SC/MP CPU bus (priority)
//            and a debug/loader port that uses the idle slots.
// Revision : 1.0 - initial release
// ============================================================================
module scmp_mem_arbiter
    import scmp_mem_pkg::*;
#(
    parameter int ADDR_W = c_DEFAULT_ADDR_W,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_d_o,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    output logic [DATA_W-1:0] cpu_d_i,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              bus_err
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;

    logic              w_rd_fall;
    logic              w_wr_fall;
    logic              w_rd_set;
    logic              w_overrun;
    logic              r_cpu_rd_pend;
    logic              r_cpu_wr_pend;
    logic [ADDR_W-1:0] r_cpu_addr_q;
    logic [DATA_W-1:0] r_cpu_wdata_q;
    logic [DATA_W-1:0] r_cpu_rdata_q;

    logic              w_ram_load;
    logic              w_ram_we_d;
    logic [ADDR_W-1:0] w_ram_addr_d;
    logic [DATA_W-1:0] w_ram_wdata_d;
    logic              w_rd_clr;
    logic              w_wr_clr;
    logic              w_cpu_cap;
    logic              w_dbg_cap;
    logic              w_dbg_ack_d;
    logic              w_unused;

    strobe_sync u_rd_sync (
        .clk      (clk),
        .rst      (rst),
        .strobe_n (cpu_rd_n),
        .fall     (w_rd_fall)
    );

    strobe_sync u_wr_sync (
        .clk      (clk),
        .rst      (rst),
        .strobe_n (cpu_wr_n),
        .fall     (w_wr_fall)
    );

    // A read edge coinciding with a write edge is dropped: the write wins.
    assign w_rd_set  = w_rd_fall & ~w_wr_fall;
    assign w_overrun = (w_rd_set & r_cpu_rd_pend) | (w_wr_fall & r_cpu_wr_pend);
    assign w_unused  = ^cpu_addr[11:ADDR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_rd_pend <= 1'b0;
            r_cpu_wr_pend <= 1'b0;
            r_cpu_addr_q  <= '0;
            r_cpu_wdata_q <= '0;
            bus_err       <= 1'b0;
        end else begin
            if (w_wr_fall)
                r_cpu_wr_pend <= 1'b1;
            else if (w_wr_clr)
                r_cpu_wr_pend <= 1'b0;
            if (w_rd_set)
                r_cpu_rd_pend <= 1'b1;
            else if (w_rd_clr)
                r_cpu_rd_pend <= 1'b0;
            if (w_rd_fall | w_wr_fall)
                r_cpu_addr_q <= cpu_addr[ADDR_W-1:0];
            if (w_wr_fall)
                r_cpu_wdata_q <= cpu_d_o;
            if ((w_rd_fall & w_wr_fall) | w_overrun)
                bus_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_cpu_wr_pend)
                    w_state_nxt = ST_CWR;
                else if (r_cpu_rd_pend)
                    w_state_nxt = ST_CRD;
                else if (dbg_req && !dbg_ack)
                    w_state_nxt = dbg_we ? ST_DWR : ST_DRD;
            end
            ST_CRD:     w_state_nxt = ST_CRD_CAP;
            ST_DRD:     w_state_nxt = ST_DRD_CAP;
            ST_CRD_CAP,
            ST_CWR,
            ST_DRD_CAP,
            ST_DWR:     w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // RAM controls are loaded on the IDLE exit so they are valid for the whole access state.
    always_comb begin
        w_ram_load    = 1'b0;
        w_ram_we_d    = 1'b0;
        w_ram_addr_d  = r_cpu_addr_q;
        w_ram_wdata_d = r_cpu_wdata_q;
        w_rd_clr      = (r_state == ST_CRD);
        w_wr_clr      = (r_state == ST_CWR);
        w_cpu_cap     = (r_state == ST_CRD_CAP);
        w_dbg_cap     = (r_state == ST_DRD_CAP);
        w_dbg_ack_d   = (r_state == ST_DWR) || (r_state == ST_DRD_CAP);
        if (r_state == ST_IDLE) begin
            case (w_state_nxt)
                ST_CWR: begin
                    w_ram_load = 1'b1;
                    w_ram_we_d = 1'b1;
                end
                ST_CRD: begin
                    w_ram_load = 1'b1;
                end
                ST_DWR: begin
                    w_ram_load    = 1'b1;
                    w_ram_we_d    = 1'b1;
                    w_ram_addr_d  = dbg_addr;
                    w_ram_wdata_d = dbg_wdata;
                end
                ST_DRD: begin
                    w_ram_load   = 1'b1;
                    w_ram_addr_d = dbg_addr;
                end
                default: begin
                    w_ram_load = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr      <= '0;
            ram_we        <= 1'b0;
            ram_wdata     <= '0;
            dbg_ack       <= 1'b0;
            dbg_rdata     <= '0;
            r_cpu_rdata_q <= DATA_W'(c_IDLE_DATA);
        end else begin
            ram_we  <= w_ram_we_d;
            dbg_ack <= w_dbg_ack_d;
            if (w_ram_load)
                ram_addr <= w_ram_addr_d;
            if (w_ram_we_d)
                ram_wdata <= w_ram_wdata_d;
            if (w_cpu_cap)
                r_cpu_rdata_q <= ram_rdata;
            if (w_dbg_cap)
                dbg_rdata <= ram_rdata;
        end
    end

    assign cpu_d_i = cpu_rd_n ? DATA_W'(c_IDLE_DATA) : r_cpu_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_scmp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_scmp_mem_arbiter
// Brief    : Randomised scoreboard bench for scmp_mem_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scmp_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_d_o;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic [7:0]  cpu_d_i;
    logic        dbg_req;
    logic        dbg_we;
    logic [6:0]  dbg_addr;
    logic [7:0]  dbg_wdata;
    logic        dbg_ack;
    logic [7:0]  dbg_rdata;
    logic [6:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        bus_err;

    logic [7:0]  ram     [128];
    logic [7:0]  ref_mem [128];
    logic [7:0]  exp_cpu [$];
    logic [8:0]  exp_dbg [$];
    logic [14:0] exp_wr  [$];

    int n_cmp  = 0;
    int n_err  = 0;
    int rd_lat = 0;
    int cyc    = 0;
    int t_ack  = 0;
    int t_wr   = 0;

    scmp_mem_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_d_o   (cpu_d_o),
        .cpu_rd_n  (cpu_rd_n),
        .cpu_wr_n  (cpu_wr_n),
        .cpu_d_i   (cpu_d_i),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .bus_err   (bus_err)
    );

    always #10 clk = ~clk;

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we)
            ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scores RAM writes, debug acks and CPU read data as the DUT presents them.
    initial begin
        int cnt;
        int idx;
        logic [8:0] e;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
            end else begin
                if (ram_we) begin
                    idx = -1;
                    for (int i = 0; i < exp_wr.size(); i++)
                        if (idx < 0 && exp_wr[i] === {ram_addr, ram_wdata})
                            idx = i;
                    n_cmp++;
                    if (idx < 0) begin
                        n_err++;
                        $display("FAIL ram_write: got addr %0h data %0h, required none pending", ram_addr, ram_wdata);
                    end else begin
                        exp_wr.delete(idx);
                    end
                    t_wr = cyc;
                end
                if (dbg_ack) begin
                    t_ack = cyc;
                    if (exp_dbg.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL dbg_ack: got ack, required none pending");
                    end else begin
                        e = exp_dbg.pop_front();
                        if (e[8])
                            check("dbg_rdata", {24'd0, dbg_rdata}, {24'd0, e[7:0]});
                    end
                end
                if (!cpu_rd_n) begin
                    cnt++;
                    if (rd_lat != 0 && cnt == rd_lat + 1) begin
                        if (exp_cpu.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL cpu_read: got %0h, required no read pending", cpu_d_i);
                        end else begin
                            check("cpu_d_i", {24'd0, cpu_d_i}, {24'd0, exp_cpu.pop_front()});
                        end
                    end
                end else begin
                    if (cnt != 0)
                        check("cpu_d_i_release", {24'd0, cpu_d_i}, 32'hFF);
                    cnt = 0;
                end
            end
        end
    end

    task automatic wait_wr(input int bound, input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            #1;
        end while (exp_wr.size() != 0 && n < bound);
        check(name, exp_wr.size(), 0);
    endtask

    task automatic dbg_op(input bit we, input logic [6:0] a, input logic [7:0] d, input int lat);
        int n;
        if (we) begin
            ref_mem[a] = d;
            exp_wr.push_back({a, d});
            exp_dbg.push_back({1'b0, d});
        end else begin
            exp_dbg.push_back({1'b1, ref_mem[a]});
        end
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = d;
        dbg_req   = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!dbg_ack && n < 20);
        dbg_req = 1'b0;
        if (!dbg_ack) begin
            n_cmp++;
            n_err++;
            $display("FAIL dbg_timeout: got no ack after %0d cycles, required ack", n);
        end else if (lat != 0) begin
            check("dbg_latency", n, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [11:0] a);
        if (rd_lat != 0)
            exp_cpu.push_back(ref_mem[a[6:0]]);
        cpu_addr = a;
        cpu_rd_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        cpu_rd_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [7:0] d, input int lat);
        ref_mem[a[6:0]] = d;
        exp_wr.push_back({a[6:0], d});
        cpu_addr = a;
        cpu_d_o  = d;
        cpu_wr_n = 1'b0;
        if (lat != 0)
            wait_wr(lat, "cpu_wr_latency");
        repeat (6) @(posedge clk);
        #1;
        cpu_wr_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] a;
        logic [6:0]  a2;
        logic [7:0]  d;
        logic [7:0]  d2;
        int          op;

        rst       = 1'b1;
        cpu_addr  = '0;
        cpu_d_o   = '0;
        cpu_rd_n  = 1'b1;
        cpu_wr_n  = 1'b1;
        dbg_req   = 1'b0;
        dbg_we    = 1'b0;
        dbg_addr  = '0;
        dbg_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_we",    {31'd0, ram_we},     0);
        check("rst_ram_addr",  {25'd0, ram_addr},   0);
        check("rst_ram_wdata", {24'd0, ram_wdata},  0);
        check("rst_dbg_ack",   {31'd0, dbg_ack},    0);
        check("rst_dbg_rdata", {24'd0, dbg_rdata},  0);
        check("rst_cpu_d_i",   {24'd0, cpu_d_i},    32'hFF);
        check("rst_bus_err",   {31'd0, bus_err},    0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Load the whole RAM through the debug port.
        for (int k = 0; k < 128; k++) begin
            d = 8'($urandom_range(0, 254));
            if (k == 'h05) d = 8'h3C;
            if (k == 'h33) d = 8'h44;
            if (k == 'h40 || k == 'h41) d = 8'h11;
            dbg_op(1'b1, 7'(k), d, 2);
        end

        // Basic CPU read, write, and debug read-back.
        rd_lat = 5;
        cpu_read(12'h085);
        cpu_write(12'h012, 8'hA5, 4);
        dbg_op(1'b0, 7'h12, 8'h00, 3);
        check("bus_err_clean", {31'd0, bus_err}, 0);

        // CPU write strobe lands while a debug read is in flight.
        fork
            dbg_op(1'b0, 7'h20, 8'h00, 3);
            begin
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                cpu_write(12'h9C4, 8'h69, 8);
            end
        join
        check("contention_order", {31'd0, (t_ack < t_wr)}, 1);
        check("contention_bus_err", {31'd0, bus_err}, 0);

        // Randomised traffic, including overlapped CPU and debug accesses on distinct addresses.
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 4);
            a  = 12'($urandom);
            a2 = 7'($urandom);
            d  = 8'($urandom);
            d2 = 8'($urandom);
            case (op)
                0: begin rd_lat = 5; cpu_read(a); end
                1: cpu_write(a, d, 4);
                2: dbg_op(1'b0, a2, 8'h00, 3);
                3: dbg_op(1'b1, a2, d2, 2);
                default: begin
                    rd_lat = 8;
                    a2 = a[6:0] + 7'($urandom_range(1, 100));
                    fork
                        begin
                            repeat ($urandom_range(0, 3)) @(posedge clk);
                            #1;
                            if ($urandom_range(0, 1) == 1)
                                cpu_read(a);
                            else
                                cpu_write(a, d, 0);
                        end
                        begin
                            repeat ($urandom_range(0, 3)) @(posedge clk);
                            #1;
                            dbg_op(1'($urandom_range(0, 1)), a2, d2, 0);
                        end
                    join
                end
            endcase
        end
        check("random_bus_err", {31'd0, bus_err}, 0);

        // Overrun: two one-cycle read strobes two clocks apart.
        rd_lat   = 0;
        cpu_addr = 12'h040;
        cpu_rd_n = 1'b0;
        @(posedge clk);
        #1;
        cpu_rd_n = 1'b1;
        @(posedge clk);
        #1;
        cpu_addr = 12'h041;
        cpu_rd_n = 1'b0;
        @(posedge clk);
        #1;
        cpu_rd_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("overrun_bus_err", {31'd0, bus_err}, 1);
        repeat (20) @(posedge clk);
        #1;
        check("bus_err_sticky", {31'd0, bus_err}, 1);

        // Reset asserted while a CPU read is in CRD.
        cpu_addr = 12'h005;
        cpu_rd_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ram_we",   {31'd0, ram_we},   0);
        check("midrst_ram_addr", {25'd0, ram_addr}, 0);
        check("midrst_cpu_d_i",  {24'd0, cpu_d_i},  32'hFF);
        check("midrst_bus_err",  {31'd0, bus_err},  0);
        check("midrst_dbg_ack",  {31'd0, dbg_ack},  0);
        cpu_rd_n = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Read and write strobes falling together: write only, error flagged.
        rd_lat = 8;
        exp_cpu.push_back(8'hFF);
        ref_mem[7'h33] = 8'h5A;
        exp_wr.push_back({7'h33, 8'h5A});
        cpu_addr = 12'hA33;
        cpu_d_o  = 8'h5A;
        cpu_rd_n = 1'b0;
        cpu_wr_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        cpu_rd_n = 1'b1;
        cpu_wr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("simul_bus_err", {31'd0, bus_err}, 1);
        dbg_op(1'b0, 7'h33, 8'h00, 3);

        repeat (5) @(posedge clk);
        #1;
        check("drain_wr",  exp_wr.size(),  0);
        check("drain_dbg", exp_dbg.size(), 0);
        check("drain_cpu", exp_cpu.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
